// File: rtl/rv_core_pkg.sv
// rtl/rv_core_pkg.sv - shared types and constants for the RV32 core front end
package rv_core_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // True for the opcodes the control unit knows how to decode
  function automatic logic is_base_opcode(input logic [6:0] op);
    return op inside {OP_R, OP_IMM, OP_LOAD, OP_STORE,
                      OP_BRANCH, OP_JALR, OP_JAL, OP_LUI};
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// rtl/fetch_next_pc.sv - next-PC selection and alignment check
module fetch_next_pc
  import rv_core_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        PCSel,
  input  logic [31:0] ALU_target,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4,
  output logic        misaligned
);

  logic [31:0] target_even;

  // Jump targets drop bit 0 (JALR semantics); pc+4 wraps naturally at 2^32
  always_comb begin
    pc_plus4    = pc + 32'd4;
    target_even = ALU_target & ~32'h1;
    next_pc     = PCSel ? target_even : pc_plus4;
    misaligned  = |next_pc[1:0];
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem handshake, instruction hold
module fetch_unit
  import rv_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        instr_ack,
  input  logic        PCSel,
  input  logic [31:0] ALU_target,
  output logic        issue_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic        funct7,
  output logic        fetch_fault,
  output logic [31:0] retired
);

  fetch_state_t state, state_next;
  logic [31:0]  next_pc;
  logic         misaligned;
  logic         instr_load;
  logic         pc_load;
  logic         retire;
  logic         fault_set;

  fetch_next_pc u_next_pc (
    .pc         (pc),
    .PCSel      (PCSel),
    .ALU_target (ALU_target),
    .next_pc    (next_pc),
    .pc_plus4   (pc_plus4),
    .misaligned (misaligned)
  );

  assign imem_addr = pc;
  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7    = instr[30];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= state_next;
  end

  // Next-state and control decode; outputs depend only on registered state
  always_comb begin
    state_next  = state;
    imem_req    = 1'b0;
    issue_valid = 1'b0;
    instr_load  = 1'b0;
    pc_load     = 1'b0;
    retire      = 1'b0;
    fault_set   = 1'b0;
    case (state)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          instr_load = 1'b1;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        issue_valid = 1'b1;
        if (instr_ack) begin
          retire = 1'b1;
          if (misaligned) begin
            fault_set  = 1'b1;
            state_next = ST_FAULT;
          end else begin
            pc_load    = 1'b1;
            state_next = ST_FETCH;
          end
        end
      end
      ST_FAULT: begin
      end
      default: state_next = ST_FETCH;
    endcase
  end

  // PC advances only on an aligned acknowledged instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pc <= RESET_PC;
    else if (pc_load) pc <= next_pc;
  end

  // Instruction register captures the response only while waiting for it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          instr <= NOP_INSTR;
    else if (instr_load) instr <= imem_rdata;
  end

  // Retire counter, wraps at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retired <= 32'd0;
    else if (retire) retired <= retired + 32'd1;
  end

  // Sticky misaligned-target fault, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         fetch_fault <= 1'b0;
    else if (fault_set) fetch_fault <= 1'b1;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_ack;
  logic        PCSel;
  logic [31:0] ALU_target;
  logic        issue_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7;
  logic        fetch_fault;
  logic [31:0] retired;

  int total = 0;
  int bad   = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_ack   (instr_ack),
    .PCSel       (PCSel),
    .ALU_target  (ALU_target),
    .issue_valid (issue_valid),
    .instr       (instr),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (funct7),
    .fetch_fault (fetch_fault),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    instr_ack   = 1'b0;
    PCSel       = 1'b0;
    ALU_target  = 32'h0;
  endtask

  // Zero-wait fetch: FETCH accepted, response next cycle, ends in HOLD
  task automatic fetch_word(input logic [31:0] data);
    imem_ready = 1'b1;
    tick();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    tick();
    imem_rvalid = 1'b0;
  endtask

  task automatic do_ack(input logic sel, input logic [31:0] target);
    instr_ack  = 1'b1;
    PCSel      = sel;
    ALU_target = target;
    tick();
    instr_ack  = 1'b0;
    PCSel      = 1'b0;
    ALU_target = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL reset_req got=%0b want=1", imem_req); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h want=00000000", imem_addr); end
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL reset_issue got=%0b want=0", issue_valid); end
    total++; if (instr !== 32'h0000_0013) begin bad++; $display("FAIL reset_instr got=%h want=00000013", instr); end
    total++; if (retired !== 32'h0) begin bad++; $display("FAIL reset_retired got=%0d want=0", retired); end
    total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%0b want=0", fetch_fault); end
  endtask

  task automatic test_basic_fetch();
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL wait_req got=%0b want=0", imem_req); end
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL wait_issue got=%0b want=0", issue_valid); end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0050_0093;
    tick();
    imem_rvalid = 1'b0;
    total++; if (issue_valid !== 1'b1) begin bad++; $display("FAIL basic_issue got=%0b want=1", issue_valid); end
    total++; if (opcode !== 7'b0010011) begin bad++; $display("FAIL basic_opcode got=%b want=0010011", opcode); end
    total++; if (funct3 !== 3'b000) begin bad++; $display("FAIL basic_funct3 got=%b want=000", funct3); end
    total++; if (instr !== 32'h0050_0093) begin bad++; $display("FAIL basic_instr got=%h want=00500093", instr); end
    total++; if (pc_plus4 !== 32'h4) begin bad++; $display("FAIL basic_pc_plus4 got=%h want=00000004", pc_plus4); end
    do_ack(1'b0, 32'h0);
    total++; if (imem_addr !== 32'h4) begin bad++; $display("FAIL basic_next_addr got=%h want=00000004", imem_addr); end
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL basic_next_req got=%0b want=1", imem_req); end
    total++; if (retired !== 32'd1) begin bad++; $display("FAIL basic_retired got=%0d want=1", retired); end
  endtask

  task automatic test_wait_states();
    // ack held high outside HOLD must be ignored
    instr_ack  = 1'b1;
    PCSel      = 1'b1;
    ALU_target = 32'h0000_0008;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin bad++; $display("FAIL ready_low_%0d req=%0b addr=%h want req=1 addr=00000004", i, imem_req, imem_addr); end
    end
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (imem_req !== 1'b0 || issue_valid !== 1'b0) begin bad++; $display("FAIL rvalid_low_%0d req=%0b issue=%0b want 0 0", i, imem_req, issue_valid); end
    end
    instr_ack   = 1'b0;
    PCSel       = 1'b0;
    ALU_target  = 32'h0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0020_8133;
    tick();
    imem_rvalid = 1'b0;
    // 3 + 1 + 2 + 1 = 7 cycles from FETCH entry, five more than the zero-wait case
    total++; if (issue_valid !== 1'b1) begin bad++; $display("FAIL wait_issue_late got=%0b want=1", issue_valid); end
    total++; if (retired !== 32'd1) begin bad++; $display("FAIL ack_ignored_retired got=%0d want=1", retired); end
    total++; if (pc !== 32'h4) begin bad++; $display("FAIL ack_ignored_pc got=%h want=00000004", pc); end
  endtask

  task automatic test_branch_target();
    do_ack(1'b1, 32'h0000_0101);
    total++; if (imem_addr !== 32'h0000_0100) begin bad++; $display("FAIL branch_addr got=%h want=00000100", imem_addr); end
    total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL branch_fault got=%0b want=0", fetch_fault); end
    total++; if (retired !== 32'd2) begin bad++; $display("FAIL branch_retired got=%0d want=2", retired); end
  endtask

  task automatic test_fault();
    fetch_word(32'h0000_0067);
    total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL fault_before_ack got=%0b want=0", fetch_fault); end
    do_ack(1'b1, 32'h0000_0102);
    total++; if (fetch_fault !== 1'b1) begin bad++; $display("FAIL fault_set got=%0b want=1", fetch_fault); end
    total++; if (pc !== 32'h0000_0100) begin bad++; $display("FAIL fault_pc_hold got=%h want=00000100", pc); end
    imem_ready  = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    instr_ack   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (imem_req !== 1'b0 || issue_valid !== 1'b0 || fetch_fault !== 1'b1) begin bad++; $display("FAIL fault_sticky_%0d req=%0b issue=%0b fault=%0b want 0 0 1", i, imem_req, issue_valid, fetch_fault); end
    end
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++; if (pc !== 32'h0 || fetch_fault !== 1'b0 || imem_req !== 1'b1) begin bad++; $display("FAIL fault_reset pc=%h fault=%0b req=%0b want 00000000 0 1", pc, fetch_fault, imem_req); end
  endtask

  task automatic test_reset_in_wait();
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL async_reset_req got=%0b want=1", imem_req); end
    tick();
    rst_n       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    total++; if (issue_valid !== 1'b0 || instr !== 32'h0000_0013) begin bad++; $display("FAIL stale_word issue=%0b instr=%h want 0 00000013", issue_valid, instr); end
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    tick();
    total++; if (instr !== 32'h0000_0013) begin bad++; $display("FAIL stale_wait_instr got=%h want=00000013", instr); end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h00A0_0113;
    tick();
    imem_rvalid = 1'b0;
    total++; if (issue_valid !== 1'b1 || instr !== 32'h00A0_0113) begin bad++; $display("FAIL real_word issue=%0b instr=%h want 1 00a00113", issue_valid, instr); end
  endtask

  task automatic test_pc_wrap();
    do_ack(1'b1, 32'hFFFF_FFFD);
    total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_setup got=%h want=fffffffc", imem_addr); end
    fetch_word(32'h0000_0013);
    total++; if (pc_plus4 !== 32'h0) begin bad++; $display("FAIL wrap_pc_plus4 got=%h want=00000000", pc_plus4); end
    do_ack(1'b0, 32'h0);
    total++; if (imem_addr !== 32'h0 || fetch_fault !== 1'b0) begin bad++; $display("FAIL wrap_addr addr=%h fault=%0b want 00000000 0", imem_addr, fetch_fault); end
  endtask

  task automatic test_retired_wrap();
    fetch_word(32'h0000_0013);
    force dut.retired = 32'hFFFF_FFFF;
    #1;
    release dut.retired;
    do_ack(1'b0, 32'h0);
    total++; if (retired !== 32'h0) begin bad++; $display("FAIL retired_wrap got=%h want=00000000", retired); end
    total++; if (fetch_fault !== 1'b0 || imem_addr !== 32'h4) begin bad++; $display("FAIL retired_wrap_next fault=%0b addr=%h want 0 00000004", fetch_fault, imem_addr); end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_basic_fetch();
    test_wait_states();
    test_branch_target();
    test_fault();
    test_reset_in_wait();
    test_pc_wrap();
    test_retired_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
